// File: rtl/rmii_rx_mac.sv
// rmii_rx_mac
// ------------
// RMII receive MAC. Consumes one 2-bit dibit per clock from the PHY and
// strips the preamble and SFD. It filters on the destination address:
// station address, optional broadcast and multicast acceptance, and a
// runtime promiscuous input. Accepted frames come out as a byte stream
// with the destination and FCS removed. The last beat carries a
// good/bad status: CRC, length and alignment.
//
// Optional build macro: MAC_RX_STATS_EN
//   defined     -> good / bad / drop statistics counters are implemented
//   not defined -> the counter outputs are tied to 0
//
// Ports
//   clk           50 MHz RMII reference clock (single domain)
//   reset         asynchronous reset, active low
//   phy_crsdv     RMII CRS_DV
//   phy_rxd[1:0]  RMII RXD; the first dibit of each byte carries bits [1:0]
//   promisc       accept every destination (sampled at the address decision)
//   axi_rx_valid  one-cycle beat strobe
//   axi_rx_data   byte for this beat
//   axi_rx_last   final beat of the frame
//   axi_rx_good   status on the last beat (CRC, length and alignment all OK)
//   rx_good_cnt / rx_bad_cnt / rx_drop_cnt   saturating statistics counters
module rmii_rx_mac #(
    parameter logic [47:0] THIS_MAC     = 48'hb8_27_eb_a4_30_73,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter bit          ACCEPT_MCAST = 1'b0,
    parameter int          MIN_LEN      = 64,
    parameter int          MAX_LEN      = 1518,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             phy_crsdv,
    input  logic [1:0]       phy_rxd,
    input  logic             promisc,
    output logic             axi_rx_valid,
    output logic [7:0]       axi_rx_data,
    output logic             axi_rx_last,
    output logic             axi_rx_good,
    output logic [CNT_W-1:0] rx_good_cnt,
    output logic [CNT_W-1:0] rx_bad_cnt,
    output logic [CNT_W-1:0] rx_drop_cnt
);

    localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);
    localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DST,
        S_DATA,
        S_DISCARD,
        S_EOF
    } state_t;

    state_t      state, state_next;
    logic        armed;
    logic [1:0]  phase;        // dibit position within the current byte
    logic [15:0] len;          // completed bytes since SFD, saturating
    logic [7:0]  byte_sr;
    logic [47:0] dst;
    logic [31:0] crc;
    logic [7:0]  pipe [5];     // pipe[4] is the oldest byte
    logic [2:0]  pipe_cnt;

    // Reflected CRC-32, two bits per call, rxd[0] first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 32'hedb88320;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] len_sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    logic        in_frame, sfd_seen, byte_done, dst_last, dst_ok;
    logic        frame_end, eof_emit, frame_good, data_push, data_emit;
    logic [7:0]  byte_next;
    logic [47:0] dst_next;

    // Dibit assembly: first dibit lands in [1:0] after four right shifts.
    assign byte_next = {phy_rxd, byte_sr[7:2]};
    assign dst_next  = {dst[39:0], byte_next};
    assign byte_done = (phase == 2'd3);
    assign in_frame  = (state == S_DST) || (state == S_DATA);
    assign sfd_seen  = (state == S_PREAMBLE) && phy_crsdv && (phy_rxd == 2'b11);
    assign dst_last  = byte_done && (len == 16'd5);
    assign dst_ok    = promisc
                    || (dst_next == THIS_MAC)
                    || (ACCEPT_BCAST && (&dst_next))
                    || (ACCEPT_MCAST && dst_next[40]);

    // crsdv dropping during DST/DATA closes the frame on this edge.
    assign frame_end  = in_frame && !phy_crsdv;
    assign eof_emit   = frame_end && (pipe_cnt == 3'd5);
    assign frame_good = (crc == CRC_RESIDUE)
                     && (len >= MIN_LEN_W) && (len <= MAX_LEN_W)
                     && (phase == 2'd0);
    assign data_push  = (state == S_DATA) && phy_crsdv && byte_done;
    assign data_emit  = data_push && (pipe_cnt == 3'd5);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (armed && phy_crsdv && (phy_rxd == 2'b01))
                    state_next = S_PREAMBLE;
                else if (phy_crsdv && (phy_rxd == 2'b10))
                    state_next = S_DISCARD;
            end
            S_PREAMBLE: begin
                if (!phy_crsdv)
                    state_next = S_IDLE;
                else if (phy_rxd == 2'b11)
                    state_next = S_DST;
                else if (phy_rxd == 2'b10)
                    state_next = S_DISCARD;
            end
            S_DST: begin
                if (!phy_crsdv)
                    state_next = S_EOF;
                else if (dst_last)
                    state_next = dst_ok ? S_DATA : S_DISCARD;
            end
            S_DATA: begin
                if (!phy_crsdv)
                    state_next = S_EOF;
            end
            S_DISCARD: begin
                if (!phy_crsdv)
                    state_next = S_IDLE;
            end
            S_EOF:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            phase        <= 2'd0;
            len          <= 16'd0;
            pipe_cnt     <= 3'd0;
            axi_rx_valid <= 1'b0;
            axi_rx_data  <= 8'd0;
            axi_rx_last  <= 1'b0;
            axi_rx_good  <= 1'b0;
        end else begin
            state <= state_next;
            if (!phy_crsdv)
                armed <= 1'b1;

            if (sfd_seen) begin
                phase    <= 2'd0;
                len      <= 16'd0;
                pipe_cnt <= 3'd0;
            end else if (in_frame && phy_crsdv) begin
                phase <= phase + 2'd1;
                if (byte_done)
                    len <= len_sat_inc(len);
                if (data_push && (pipe_cnt != 3'd5))
                    pipe_cnt <= pipe_cnt + 3'd1;
            end

            axi_rx_valid <= data_emit || eof_emit;
            axi_rx_last  <= eof_emit;
            axi_rx_good  <= eof_emit && frame_good;
            if (data_emit || eof_emit)
                axi_rx_data <= pipe[4];
        end
    end

    // Datapath registers: every use is gated by control state, so no reset.
    always_ff @(posedge clk) begin
        if (sfd_seen)
            crc <= 32'hffffffff;
        else if (in_frame && phy_crsdv)
            crc <= crc_dibit(crc, phy_rxd);

        if (in_frame && phy_crsdv)
            byte_sr <= byte_next;

        if ((state == S_DST) && phy_crsdv && byte_done)
            dst <= dst_next;

        // The 5-deep pipe holds back the trailing FCS bytes.
        if (data_push) begin
            pipe[0] <= byte_next;
            for (int i = 1; i < 5; i++)
                pipe[i] <= pipe[i-1];
        end
    end

`ifdef MAC_RX_STATS_EN
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic drop_evt;
    // Filter reject, or a frame closing before the pipe filled (too short).
    assign drop_evt = ((state == S_DST) && phy_crsdv && dst_last && !dst_ok)
                   || (frame_end && (pipe_cnt != 3'd5));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_good_cnt <= '0;
            rx_bad_cnt  <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (eof_emit && frame_good)
                rx_good_cnt <= cnt_inc(rx_good_cnt);
            if (eof_emit && !frame_good)
                rx_bad_cnt <= cnt_inc(rx_bad_cnt);
            if (drop_evt)
                rx_drop_cnt <= cnt_inc(rx_drop_cnt);
        end
    end
`else
    assign rx_good_cnt = '0;
    assign rx_bad_cnt  = '0;
    assign rx_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rmii_rx_mac.sv
// tb_rmii_rx_mac
// --------------
// Bench for rmii_rx_mac. It builds Ethernet frames with their own FCS and
// drives them as RMII dibits. A table of frames, each with hand-counted
// beat counts, good flags and cumulative counter values, is applied in a
// loop. Hand-written sequences cover latency and a mid-frame reset.
module tb_rmii_rx_mac;

    localparam logic [47:0] STA = 48'hb827eba43073;

    logic        clk;
    logic        reset;
    logic        phy_crsdv;
    logic [1:0]  phy_rxd;
    logic        promisc;
    logic        axi_rx_valid;
    logic [7:0]  axi_rx_data;
    logic        axi_rx_last;
    logic        axi_rx_good;
    logic [15:0] rx_good_cnt, rx_bad_cnt, rx_drop_cnt;

    rmii_rx_mac dut (
        .clk          (clk),
        .reset        (reset),
        .phy_crsdv    (phy_crsdv),
        .phy_rxd      (phy_rxd),
        .promisc      (promisc),
        .axi_rx_valid (axi_rx_valid),
        .axi_rx_data  (axi_rx_data),
        .axi_rx_last  (axi_rx_last),
        .axi_rx_good  (axi_rx_good),
        .rx_good_cnt  (rx_good_cnt),
        .rx_bad_cnt   (rx_bad_cnt),
        .rx_drop_cnt  (rx_drop_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Beat monitor, sampled on the falling edge.
    logic [7:0] got_data [$];
    bit         got_last [$];
    bit         got_good [$];
    int         first_cyc, last_cyc;

    always @(negedge clk) begin
        if (axi_rx_valid) begin
            got_data.push_back(axi_rx_data);
            got_last.push_back(axi_rx_last);
            got_good.push_back(axi_rx_good);
            if (got_data.size() == 1)
                first_cyc = cyc;
            if (axi_rx_last)
                last_cyc = cyc;
        end
    end

    task automatic clear_got();
        got_data.delete();
        got_last.delete();
        got_good.delete();
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    // Frame construction with a bench-side bytewise CRC-32.
    logic [7:0] frm [0:1599];
    int         frm_len;

    task automatic build_frame(input logic [47:0] dst, input int n, input bit flip);
        logic [31:0] c;
        for (int i = 0; i < 6; i++)
            frm[i] = dst[47-8*i -: 8];
        for (int i = 6; i < n; i++)
            frm[i] = 8'(i * 37 + 5);
        if (n >= 14) begin
            frm[12] = 8'h08;
            frm[13] = 8'h00;
        end
        if (n >= 10) begin
            c = 32'hffffffff;
            for (int i = 0; i < n - 4; i++)
                for (int b = 0; b < 8; b++)
                    c = (c[0] ^ frm[i][b]) ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
            c = ~c;
            for (int i = 0; i < 4; i++)
                frm[n-4+i] = c[8*i +: 8];
        end
        if (flip)
            frm[20][3] = ~frm[20][3];
        frm_len = n;
    endtask

    task automatic drive(input logic dv, input logic [1:0] d);
        @(posedge clk);
        #1;
        phy_crsdv = dv;
        phy_rxd   = d;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        for (int d = 0; d < 4; d++)
            drive(1'b1, b[2*d +: 2]);
    endtask

    int lat_b11, lat_eof;

    task automatic send_frame(input bit extra);
        for (int i = 0; i < 7; i++)
            drive_byte(8'h55);
        drive_byte(8'hd5);
        for (int i = 0; i < frm_len; i++) begin
            drive_byte(frm[i]);
            if (i == 11)
                lat_b11 = cyc;
        end
        if (extra)
            drive(1'b1, 2'b00);
        drive(1'b0, 2'b00);
        lat_eof = cyc;
        repeat (12) drive(1'b0, 2'b00);
    endtask

    task automatic check_frame(input string tag, input int beats, input bit good);
        int bad_data;
        int last_pos;
        int n_last;
        bad_data = 0;
        last_pos = -1;
        n_last   = 0;
        check({tag, "_beats"}, got_data.size(), beats);
        for (int k = 0; k < got_data.size(); k++) begin
            if (k < beats && got_data[k] != frm[6+k])
                bad_data++;
            if (got_last[k]) begin
                n_last++;
                last_pos = k;
            end
        end
        check({tag, "_data_errors"}, bad_data, 0);
        if (beats > 0) begin
            check({tag, "_last_pos"}, last_pos, beats - 1);
            check({tag, "_last_count"}, n_last, 1);
            check({tag, "_good"}, (last_pos >= 0) ? int'(got_good[last_pos]) : -1, good);
        end
    endtask

    function automatic int stat(input int v);
`ifdef MAC_RX_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    typedef struct {
        logic [47:0] dst;
        int          len;
        bit          prom;
        bit          flip;
        bit          extra;
        int          beats;
        bit          good;
        int          gcnt;
        int          bcnt;
        int          dcnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          dst               len  prm flp ext beats good  g  b  d
        vecs[0]  = '{STA,             64,   0,  0,  0,   54, 1,    1, 0, 0};
        vecs[1]  = '{STA,             64,   0,  1,  0,   54, 0,    1, 1, 0};
        vecs[2]  = '{48'h020000000001, 64,  0,  0,  0,    0, 0,    1, 1, 1};
        vecs[3]  = '{48'h020000000001, 64,  1,  0,  0,   54, 1,    2, 1, 1};
        vecs[4]  = '{48'hffffffffffff, 64,  0,  0,  0,   54, 1,    3, 1, 1};
        vecs[5]  = '{48'hffffffffffff, 8,   0,  0,  0,    0, 0,    3, 1, 2};
        vecs[6]  = '{STA,             64,   0,  0,  1,   54, 0,    3, 2, 2};
        vecs[7]  = '{48'h01005e000001, 64,  0,  0,  0,    0, 0,    3, 2, 3};
        vecs[8]  = '{STA,             60,   0,  0,  0,   50, 0,    3, 3, 3};
        vecs[9]  = '{STA,             1518, 0,  0,  0, 1508, 1,    4, 3, 3};
        vecs[10] = '{STA,             1519, 0,  0,  0, 1509, 0,    4, 4, 3};
        vecs[11] = '{STA,             100,  0,  0,  0,   90, 1,    5, 4, 3};

        reset     = 1'b0;
        phy_crsdv = 1'b0;
        phy_rxd   = 2'b00;
        promisc   = 1'b0;
        clear_got();
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", axi_rx_valid, 0);
        check("reset_last",  axi_rx_last, 0);
        check("reset_good",  axi_rx_good, 0);
        check("reset_data",  axi_rx_data, 0);
        check("reset_cnts",  rx_good_cnt | rx_bad_cnt | rx_drop_cnt, 0);
        reset = 1'b1;
        repeat (4) drive(1'b0, 2'b00);

        for (int v = 0; v < 12; v++) begin
            build_frame(vecs[v].dst, vecs[v].len, vecs[v].flip);
            promisc = vecs[v].prom;
            clear_got();
            send_frame(vecs[v].extra);
            check_frame($sformatf("v%0d", v), vecs[v].beats, vecs[v].good);
            check($sformatf("v%0d_good_cnt", v), rx_good_cnt, stat(vecs[v].gcnt));
            check($sformatf("v%0d_bad_cnt", v),  rx_bad_cnt,  stat(vecs[v].bcnt));
            check($sformatf("v%0d_drop_cnt", v), rx_drop_cnt, stat(vecs[v].dcnt));
            if (v == 0) begin
                check("lat_first_beat", first_cyc, lat_b11 + 1);
                check("lat_last_beat",  last_cyc,  lat_eof + 1);
            end
        end
        promisc = 1'b0;

        // Reset asserted mid-payload with carrier held high.
        build_frame(STA, 64, 1'b0);
        for (int i = 0; i < 7; i++)
            drive_byte(8'h55);
        drive_byte(8'hd5);
        for (int i = 0; i < 30; i++)
            drive_byte(frm[i]);
        drive(1'b1, frm[30][1:0]);
        #5;
        reset = 1'b0;
        #1;
        check("midrst_valid", axi_rx_valid, 0);
        check("midrst_last",  axi_rx_last, 0);
        check("midrst_good",  axi_rx_good, 0);
        check("midrst_data",  axi_rx_data, 0);
        check("midrst_cnts",  rx_good_cnt | rx_bad_cnt | rx_drop_cnt, 0);
        clear_got();
        drive(1'b1, frm[30][3:2]);
        drive(1'b1, frm[30][5:4]);
        reset = 1'b1;
        drive(1'b1, frm[30][7:6]);
        for (int i = 31; i < 64; i++)
            drive_byte(frm[i]);
        drive(1'b0, 2'b00);
        repeat (12) drive(1'b0, 2'b00);
        check("midrst_no_beats", got_data.size(), 0);
        check("midrst_cnts_after", rx_good_cnt | rx_bad_cnt | rx_drop_cnt, 0);

        clear_got();
        send_frame(1'b0);
        check_frame("post_rst", 54, 1'b1);
        check("post_rst_good_cnt", rx_good_cnt, stat(1));
        check("post_rst_drop_cnt", rx_drop_cnt, stat(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
